// File: rtl/fuzzy_tuner_pkg.sv
// Shared types and width helpers for the fuzzy gain scheduler.
//   state_e           : sequencing FSM states
//   IDX_N/IDX_Z/IDX_P : membership slot indices (negative / zero / positive)
//   mem_w/den_w/num_w : derived widths from the saturation range and gain width
package fuzzy_tuner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FUZZ,
    ST_RULE,
    ST_DIV,
    ST_DONE
  } state_e;

  localparam logic [1:0] IDX_N = 2'd0;
  localparam logic [1:0] IDX_Z = 2'd1;
  localparam logic [1:0] IDX_P = 2'd2;

  // A membership value spans 0..SAT.
  function automatic int mem_w(input int sat);
    return $clog2(sat + 1);
  endfunction

  // Sum of three memberships.
  function automatic int den_w(input int sat);
    return mem_w(sat) + 2;
  endfunction

  // Sum of three membership*singleton products.
  function automatic int num_w(input int sat, input int gain_w);
    return mem_w(sat) + gain_w + 2;
  endfunction

endpackage

// File: rtl/gain_divider.sv
// Serial restoring divider, one quotient bit per enabled cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance enable; low holds every register
//   start      : load num/den and begin a NUM_W-step division
//   num, den   : dividend / divisor
//   quotient   : floor(num/den), valid once the final step has retired
//   done       : high during the cycle whose edge retires the last bit
module gain_divider #(
  parameter int NUM_W = 10,
  parameter int DEN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  // quo_q starts as the dividend; dividend bits shift out of the top while
  // quotient bits shift in at the bottom.
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [DEN_W:0]   rem_sh;
  logic             ge;

  assign quotient = quo_q;
  assign done     = run_q && (cnt_q == CNT_W'(NUM_W - 1));

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    rem_sh = {rem_q, quo_q[NUM_W-1]};
    ge     = (rem_sh >= {1'b0, den_q});
    if (start) begin
      quo_d = num;
      rem_d = '0;
      den_d = den;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      // Remainder always ends below den, so it fits DEN_W bits.
      rem_d = ge ? DEN_W'(rem_sh - {1'b0, den_q}) : DEN_W'(rem_sh);
      quo_d = {quo_q[NUM_W-2:0], ge};
      cnt_d = cnt_q + 1'b1;
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (en) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/fuzzy_gain_scheduler.sv
// Multi-cycle fuzzy PD gain scheduler. Fuzzifies velocity error and its
// change, evaluates a 3x3 rule table and defuzzifies Kp/Kd by weighted
// average using two serial dividers.
//   clk, rst_n              : clock, synchronous active-low reset
//   enable                  : low freezes FSM and all registers
//   start                   : sample request, accepted when idle
//   target_vel, current_vel : velocities captured on accept
//   kp, kd                  : gains, updated only in the valid cycle
//   valid                   : one-cycle update pulse
//   busy                    : high from accept until the update cycle
module fuzzy_gain_scheduler
  import fuzzy_tuner_pkg::*;
#(
  parameter int VEL_W  = 10,
  parameter int GAIN_W = 4,
  parameter int SAT    = 10,
  parameter int KP_S   = 1,
  parameter int KP_M   = 4,
  parameter int KP_L   = 7,
  parameter int KD_S   = 2,
  parameter int KD_M   = 9,
  parameter int KD_L   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [VEL_W-1:0]  target_vel,
  input  logic [VEL_W-1:0]  current_vel,
  output logic [GAIN_W-1:0] kp,
  output logic [GAIN_W-1:0] kd,
  output logic              valid,
  output logic              busy
);

  localparam int MW    = mem_w(SAT);
  localparam int E_W   = VEL_W + 1;
  localparam int D_W   = E_W + 1;           // delta-error needs one more bit
  localparam int DEN_W = den_w(SAT);
  localparam int NUM_W = num_w(SAT, GAIN_W);

  localparam logic signed [D_W-1:0] SAT_S = D_W'(SAT);

  state_e                   state_q, state_d;
  logic [VEL_W-1:0]         tgt_q, tgt_d, cur_q, cur_d;
  logic signed [E_W-1:0]    e_q, e_d, prev_q, prev_d;
  logic [2:0][MW-1:0]       me_q, me_d, mde_q, mde_d;
  logic                     kp_dz_q, kp_dz_d, kd_dz_q, kd_dz_d;
  logic [GAIN_W-1:0]        kp_q, kp_d, kd_q, kd_d;
  logic                     valid_q, valid_d;

  logic signed [D_W-1:0]    e_full, de_full;
  logic [2:0][2:0][MW-1:0]  m;
  logic [MW-1:0]            kp_ws, kp_wm, kp_wl, kd_ws, kd_wm, kd_wl;
  logic [NUM_W-1:0]         kp_num, kd_num, kp_quo, kd_quo;
  logic [DEN_W-1:0]         kp_den, kd_den;
  logic                     div_start, kp_done, kd_done;
  logic [GAIN_W-1:0]        kp_sat, kd_sat;

  assign kp    = kp_q;
  assign kd    = kd_q;
  assign valid = valid_q;
  assign busy  = (state_q != ST_IDLE);

  // Clamp to [-SAT, SAT] and split into N/Z/P; the three always sum to SAT.
  function automatic logic [2:0][MW-1:0] memb(input logic signed [D_W-1:0] x);
    logic signed [D_W-1:0] xc;
    logic [2:0][MW-1:0]    r;
    if (x > SAT_S)       xc = SAT_S;
    else if (x < -SAT_S) xc = -SAT_S;
    else                 xc = x;
    r = '0;
    if (xc[D_W-1]) begin
      r[IDX_N] = MW'(-xc);
      r[IDX_Z] = MW'(SAT_S + xc);
    end else begin
      r[IDX_Z] = MW'(SAT_S - xc);
      r[IDX_P] = MW'(xc);
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] max2(input logic [MW-1:0] a, input logic [MW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign e_full  = $signed({2'b00, tgt_q}) - $signed({2'b00, cur_q});
  assign de_full = e_full - $signed({prev_q[E_W-1], prev_q});

  // Rule firing strengths and weighted-average operands.
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[i][j] = (me_q[i] < mde_q[j]) ? me_q[i] : mde_q[j];
    kp_ws = m[1][1];
    kp_wm = max2(max2(max2(m[1][0], m[0][1]), max2(m[2][1], m[1][2])),
                 max2(m[0][0], m[2][2]));
    kp_wl = max2(m[0][2], m[2][0]);
    kd_ws = max2(max2(m[0][2], m[2][0]), m[1][1]);
    kd_wm = max2(max2(m[0][0], m[0][1]), max2(m[2][1], m[2][2]));
    kd_wl = max2(m[1][0], m[1][2]);
    kp_num = NUM_W'(kp_ws) * NUM_W'(KP_S) + NUM_W'(kp_wm) * NUM_W'(KP_M)
           + NUM_W'(kp_wl) * NUM_W'(KP_L);
    kd_num = NUM_W'(kd_ws) * NUM_W'(KD_S) + NUM_W'(kd_wm) * NUM_W'(KD_M)
           + NUM_W'(kd_wl) * NUM_W'(KD_L);
    kp_den = DEN_W'(kp_ws) + DEN_W'(kp_wm) + DEN_W'(kp_wl);
    kd_den = DEN_W'(kd_ws) + DEN_W'(kd_wm) + DEN_W'(kd_wl);
  end

  assign kp_sat = (|kp_quo[NUM_W-1:GAIN_W]) ? {GAIN_W{1'b1}} : kp_quo[GAIN_W-1:0];
  assign kd_sat = (|kd_quo[NUM_W-1:GAIN_W]) ? {GAIN_W{1'b1}} : kd_quo[GAIN_W-1:0];

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    e_d       = e_q;
    prev_d    = prev_q;
    me_d      = me_q;
    mde_d     = mde_q;
    kp_dz_d   = kp_dz_q;
    kd_dz_d   = kd_dz_q;
    kp_d      = kp_q;
    kd_d      = kd_q;
    valid_d   = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        tgt_d   = target_vel;
        cur_d   = current_vel;
        state_d = ST_FUZZ;
      end
      ST_FUZZ: begin
        e_d     = E_W'(e_full);
        me_d    = memb(e_full);
        mde_d   = memb(de_full);
        state_d = ST_RULE;
      end
      ST_RULE: begin
        div_start = 1'b1;
        kp_dz_d   = (kp_den == '0);
        kd_dz_d   = (kd_den == '0);
        state_d   = ST_DIV;
      end
      ST_DIV: if (kp_done && kd_done) state_d = ST_DONE;
      ST_DONE: begin
        // A zero weight sum leaves that gain untouched.
        if (!kp_dz_q) kp_d = kp_sat;
        if (!kd_dz_q) kd_d = kd_sat;
        valid_d = 1'b1;
        prev_d  = e_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      cur_q   <= '0;
      e_q     <= '0;
      prev_q  <= '0;
      me_q    <= '0;
      mde_q   <= '0;
      kp_dz_q <= 1'b0;
      kd_dz_q <= 1'b0;
      kp_q    <= '0;
      kd_q    <= '0;
      valid_q <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      e_q     <= e_d;
      prev_q  <= prev_d;
      me_q    <= me_d;
      mde_q   <= mde_d;
      kp_dz_q <= kp_dz_d;
      kd_dz_q <= kd_dz_d;
      kp_q    <= kp_d;
      kd_q    <= kd_d;
      valid_q <= valid_d;
    end
  end

  gain_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_kp_div (
    .clk(clk), .rst_n(rst_n), .en(enable), .start(div_start),
    .num(kp_num), .den(kp_den), .quotient(kp_quo), .done(kp_done)
  );

  gain_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_kd_div (
    .clk(clk), .rst_n(rst_n), .en(enable), .start(div_start),
    .num(kd_num), .den(kd_den), .quotient(kd_quo), .done(kd_done)
  );

endmodule

// File: doc/fuzzy_gain_scheduler.md
# fuzzy_gain_scheduler

Parametrised, multi-cycle successor to the combinational fuzzy PD tuner in the BLDC speed loop. It takes target and measured velocity, builds error and delta-error memberships over a configurable saturation range, and evaluates the 3×3 rule table. Gains are defuzzified with a weighted-average serial divider. Kp/Kd are delivered to the PD controller with a start/valid/busy handshake. All three memberships are recomputed on every sample, so no membership value carries over from a previous sample.

## Interface
- VEL_W, 10, velocity input width (unsigned)
- GAIN_W, 4, Kp/Kd output width
- SAT, 10, membership full-scale; |error| ≥ SAT saturates
- KP_S / KP_M / KP_L, 1 / 4 / 7, Kp output singletons (each < 2^GAIN_W)
- KD_S / KD_M / KD_L, 2 / 9 / 12, Kd output singletons (each < 2^GAIN_W)
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  high = run; low = freeze FSM and hold all registers
- start  in  1  sample request; accepted only when busy=0 and enable=1
- target_vel  in  VEL_W  commanded velocity, captured on accept
- current_vel  in  VEL_W  measured velocity, captured on accept
- kp  out  GAIN_W  proportional gain, held between updates
- kd  out  GAIN_W  derivative gain, held between updates
- valid  out  1  one-cycle pulse on the cycle kp/kd update
- busy  out  1  high from accept until the update cycle

## Operation
- Derived widths:
  - MW = clog2(SAT+1)
  - E_W = VEL_W+1 (signed)
  - DEN_W = MW+2
  - NUM_W = MW+GAIN_W+2
- FSM states and transitions: IDLE → FUZZ → RULE → DIV → DONE → IDLE.
- IDLE: on start & enable, capture both velocities and go to FUZZ.
- FUZZ:
  - e = target − current.
  - de = e − prev_error.
  - Clamp both to [−SAT, SAT].
  - Memberships: N = max(0,−x), Z = SAT−|x|, P = max(0,x). N+Z+P = SAT always.
- RULE:
  - m[i][j] = min(E_i, dE_j), with i,j ∈ {N=0, Z=1, P=2}.
  - Kp weights:
    - S = m11
    - M = max(m10, m01, m21, m12, m00, m22)
    - L = max(m02, m20)
  - Kd weights:
    - S = max(m02, m20, m11)
    - M = max(m00, m01, m21, m22)
    - L = max(m10, m12)
  - num = Σ w·singleton; den = Σ w.
- DIV:
  - Two restoring dividers run in parallel, one quotient bit per cycle, NUM_W cycles.
  - Quotient is floor(num/den), saturated to 2^GAIN_W−1.
- DONE:
  - Register kp/kd from the quotients and pulse valid.
  - Update prev_error ← e. prev_error changes only here.
- Divide-by-zero: den=0 cannot occur by construction. If it does, the affected gain holds its previous value.
- enable=0 in any state: the state, the cycle counter and every register hold. start is ignored.
- start while busy=1 is dropped and not queued.

## Timing
- Reset (rst_n low at an edge):
  - kp=0, kd=0, valid=0, busy=0
  - state=IDLE
  - prev_error=0
  - This applies identically mid-operation; the in-flight sample is discarded.
- Start accepted at edge k:
  - busy=1 from edge k.
  - kp/kd update and valid=1 at edge k+3+NUM_W (13 cycles with defaults).
  - busy=0 in that same cycle.
- In the valid cycle, FSM = IDLE, so a new start in that cycle is accepted at the next edge. Back-to-back throughput is 1 sample per NUM_W+4 cycles.
- Each cycle enable is low while busy extends latency by exactly one cycle.
- kp/kd never change outside the valid cycle.

## Structure
- Package fuzzy_tuner_pkg:
  - FSM state enum
  - membership index constants N/Z/P
  - clog2-based width helper functions
- Sub-module gain_divider: serial restoring divider with parameters NUM_W and DEN_W and ports start/num/den/quotient/done. It is instantiated twice, once for Kp and once for Kd.
- Rule-to-weight mapping stays in the top level.

## Test plan
- Reset, then target=100, current=100 → e=0, de=0 → kp=1, kd=2; valid exactly 13 cycles after start.
- From reset, target=200, current=100 → kp=4, kd=9. Next sample 100/100 (de=−100) → kp=4, kd=12.
- From reset, target=105, current=100 → kp=2 (25/10), kd=7 (115/15).
- From reset, target=100, current=103 → kp=1 (19/10), kd=5 (77/13).
- Deassert enable for 5 cycles during DIV → valid at cycle 18. A start pulsed while busy is ignored and prev_error is unchanged.
- rst_n low for 1 cycle mid-DIV → kp=kd=0 and busy=0 next cycle. Then 105/100 → kp=2, kd=7, confirming prev_error was cleared.
